// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select codes, opcodes, bubble word and the IF/ID payload.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [SEL_W-1:0] {
    PC_SEL_SEQ    = 2'b00,
    PC_SEL_BRANCH = 2'b01,
    PC_SEL_JUMP   = 2'b10,
    PC_SEL_RSVD   = 2'b11
  } pc_sel_e;

  localparam logic [5:0]      OPCODE_BEQ = 6'b000100;
  localparam logic [5:0]      OPCODE_J   = 6'b000010;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // j target: 256MB region of the jumping instruction's PC+4, word-aligned index
  function automatic logic [XLEN-1:0] jump_target(input logic [3:0]        region,
                                                  input logic [JIDX_W-1:0] index);
    return {region, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_stage_if_id_reg.sv
// IF/ID pipeline register; flush and reset both load a bubble, hold freezes contents.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t bubble;

  assign bubble = '{instr: BUBBLE_INSTR, pc_plus4: '0, valid: 1'b0};

  // flush outranks hold so a stalled instruction is squashed on redirect
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q <= bubble;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: program counter, redirect on taken beq/j, IF/ID register.
// Optional FETCH_REDIRECT_COUNT_EN adds a saturating 16-bit redirect counter output.
module fetch_pc_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  control_mux_for_PC,
  input  logic [XLEN-1:0]   branch_target_step_4,
  input  logic [JIDX_W-1:0] jump_index_step_4,
  input  logic [XLEN-1:0]   pc_plus4_step_4,
  input  logic              stall,
  input  logic [XLEN-1:0]   instr_in,
  output logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   instr_step_2,
  output logic [XLEN-1:0]   pc_plus4_step_2,
  output logic              valid_step_2,
  output logic              flush_younger
`ifdef FETCH_REDIRECT_COUNT_EN
  ,
  output logic [CNT_W-1:0]  redirect_count
`endif
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] target;
  logic            redirect;
  pc_sel_e         sel;
  if_id_t          if_id_d;
  if_id_t          if_id_q;
  logic            unused_bits;

  assign sel    = pc_sel_e'(control_mux_for_PC);
  assign pc_seq = pc + XLEN'(4);

  // Redirect decode; reserved select behaves as sequential
  always_comb begin
    redirect = 1'b0;
    target   = '0;
    case (sel)
      PC_SEL_BRANCH: begin
        redirect = 1'b1;
        target   = {branch_target_step_4[XLEN-1:2], 2'b00};
      end
      PC_SEL_JUMP: begin
        redirect = 1'b1;
        target   = jump_target(pc_plus4_step_4[XLEN-1:XLEN-4], jump_index_step_4);
      end
      default: begin
        redirect = 1'b0;
        target   = '0;
      end
    endcase
  end

  assign unused_bits = ^{branch_target_step_4[1:0], pc_plus4_step_4[XLEN-5:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (!stall) begin
      pc <= pc_seq;
    end
  end

  assign if_id_d = '{instr: instr_in, pc_plus4: pc_seq, valid: 1'b1};

  if_id_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .rst   (rst),
    .hold  (stall),
    .flush (redirect),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign imem_addr       = pc;
  assign instr_step_2    = if_id_q.instr;
  assign pc_plus4_step_2 = if_id_q.pc_plus4;
  assign valid_step_2    = if_id_q.valid;
  assign flush_younger   = redirect;

`ifdef FETCH_REDIRECT_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count <= '0;
    end else if (redirect && (redirect_count != {CNT_W{1'b1}})) begin
      redirect_count <= redirect_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: directed scenarios then random traffic against a reference model.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  control_mux_for_PC = 2'b00;
  logic [31:0] branch_target_step_4 = '0;
  logic [25:0] jump_index_step_4 = '0;
  logic [31:0] pc_plus4_step_4 = '0;
  logic        stall = 1'b0;
  logic [31:0] instr_in = '0;
  logic [31:0] imem_addr;
  logic [31:0] instr_step_2;
  logic [31:0] pc_plus4_step_2;
  logic        valid_step_2;
  logic        flush_younger;
`ifdef FETCH_REDIRECT_COUNT_EN
  logic [15:0] redirect_count;
`endif

  fetch_pc_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .control_mux_for_PC   (control_mux_for_PC),
    .branch_target_step_4 (branch_target_step_4),
    .jump_index_step_4    (jump_index_step_4),
    .pc_plus4_step_4      (pc_plus4_step_4),
    .stall                (stall),
    .instr_in             (instr_in),
    .imem_addr            (imem_addr),
    .instr_step_2         (instr_step_2),
    .pc_plus4_step_2      (pc_plus4_step_2),
    .valid_step_2         (valid_step_2),
    .flush_younger        (flush_younger)
`ifdef FETCH_REDIRECT_COUNT_EN
    ,
    .redirect_count       (redirect_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_pp4   = '0;
  logic        m_valid = 1'b0;
  int unsigned m_cnt   = 0;
  bit          m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registers
  task automatic step(input logic r, input logic [1:0] s, input logic st,
                      input logic [31:0] bt, input logic [25:0] ji,
                      input logic [31:0] pp4, input logic [31:0] ins);
    logic        is_redirect;
    logic [31:0] tgt;
    rst = r; control_mux_for_PC = s; stall = st;
    branch_target_step_4 = bt; jump_index_step_4 = ji;
    pc_plus4_step_4 = pp4; instr_in = ins;
    is_redirect = (s == 2'd1) || (s == 2'd2);
    if (s == 2'd1) tgt = bt & 32'hFFFF_FFFC;
    else           tgt = (pp4 & 32'hF000_0000) | ({6'b0, ji} << 2);
    #1;
    check("flush_younger", 32'(flush_younger), 32'(is_redirect));
    if (m_known) check("imem_addr_pre", imem_addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 0; m_known = 1'b1;
    end else if (is_redirect) begin
      m_pc = tgt; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (!st) begin
      m_instr = ins; m_pp4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("instr_step_2", instr_step_2, m_instr);
    check("pc_plus4_step_2", pc_plus4_step_2, m_pp4);
    check("valid_step_2", 32'(valid_step_2), 32'(m_valid));
`ifdef FETCH_REDIRECT_COUNT_EN
    check("redirect_count", 32'(redirect_count), m_cnt);
`endif
    @(negedge clk);
  endtask

  task automatic seq(input logic [31:0] ins);
    step(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, ins);
  endtask

  initial begin
    #1;
    // Reset held two cycles
    step(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'hDEAD_BEEF);
    step(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'hDEAD_BEEF);
    check("reset_imem_addr", imem_addr, 32'h0);
    check("reset_valid", 32'(valid_step_2), 32'h0);
    check("reset_instr", instr_step_2, 32'h0);

    // First fetch after release, then sequential run
    seq(32'h1111_0001);
    check("first_pp4", pc_plus4_step_2, 32'h4);
    check("first_instr", instr_step_2, 32'h1111_0001);
    for (int i = 0; i < 3; i++) seq($urandom);
    check("seq_pc16", imem_addr, 32'd16);

    // Taken branch, then its target lands in IF/ID
    step(1'b0, 2'b01, 1'b0, 32'h0000_0040, 26'h0, 32'h0, 32'h2222_0000);
    check("branch_pc", imem_addr, 32'h40);
    check("branch_bubble", 32'(valid_step_2), 32'h0);
    seq(32'h3333_0000);
    check("branch_after_pp4", pc_plus4_step_2, 32'h44);
    check("branch_after_valid", 32'(valid_step_2), 32'h1);

    // Jump, and branch target with low bits set
    step(1'b0, 2'b10, 1'b0, 32'h0, 26'h000_0100, 32'hA000_0010, $urandom);
    check("jump_pc", imem_addr, 32'hA000_0400);
    step(1'b0, 2'b01, 1'b0, 32'h0000_0103, 26'h0, 32'h0, $urandom);
    check("branch_align", imem_addr, 32'h0000_0100);
    seq(32'h4444_0000);

    // Stall holds for three edges, then a jump overrides a stall
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 1'b1, 32'h0, 26'h0, 32'h0, $urandom);
    check("stall_pp4", pc_plus4_step_2, 32'h104);
    step(1'b0, 2'b10, 1'b1, 32'h0, 26'h3FF_FFFF, 32'h1234_5678, $urandom);
    check("stall_jump_pc", imem_addr, 32'h1FFF_FFFC);

    // Wrap with reserved select
    step(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFC, 26'h0, 32'h0, $urandom);
    step(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, 32'h0, 32'h5555_0000);
    check("wrap_pc", imem_addr, 32'h0);
    check("wrap_valid", 32'(valid_step_2), 32'h1);

    // Reset during redirect and stall, then three redirects back-to-back
    step(1'b1, 2'b01, 1'b1, 32'h8000_0000, 26'h0, 32'h0, $urandom);
    check("rst_redirect_pc", imem_addr, 32'h0);
    step(1'b0, 2'b01, 1'b0, 32'h0000_0080, 26'h0, 32'h0, $urandom);
    step(1'b0, 2'b10, 1'b0, 32'h0, 26'h000_0020, 32'h7000_0000, $urandom);
    step(1'b0, 2'b01, 1'b0, 32'h0000_0200, 26'h0, 32'h0, $urandom);
    check("b2b_pc", imem_addr, 32'h200);
`ifdef FETCH_REDIRECT_COUNT_EN
    check("count_three", 32'(redirect_count), 32'd3);
    step(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, $urandom);
    check("count_reset", 32'(redirect_count), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 3), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0), $urandom, 26'($urandom), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
